mac_cfg_loader: RTL and testbench

Front-end configuration source for `mac_cluster`. It accepts a configuration frame as a byte-wide valid/ready stream and assembles it in a shadow register. On a correctly framed frame it presents the full `cfg` word with a one-cycle `cset` strobe, then drives `en`. It lets a host (DMA or CSR bridge) reconfigure the cluster and preload its accumulators without a wide parallel bus.

---
 rtl/mac_pkg.sv | 35 +++
 rtl/mac_cfg_loader.sv | 117 +++++++++++
 tb/tb_mac_cfg_loader.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/mac_pkg.sv
// Shared encodings and derived sizes for the MAC cluster configuration path.
package mac_pkg;

    // Lane-split mode in cfg[1:0]
    localparam logic [1:0] MAC_SINGLE = 2'b00;
    localparam logic [1:0] MAC_DUAL   = 2'b01;
    localparam logic [1:0] MAC_QUAD   = 2'b10;

    localparam int MODE_ACC_BIT    = 2;
    localparam int MODE_SIGNED_BIT = 3;

    typedef enum logic [1:0] {
        EMPTY  = 2'd0,
        COMMIT = 2'd1,
        RUN    = 2'd2
    } ldr_state_e;

    // Mode bits at the bottom, followed by four per-lane accumulator preloads
    function automatic int cfg_width(input int conf_w, input int acc_w);
        return 4 * acc_w + conf_w;
    endfunction

    function automatic int num_beats(input int cfg_w, input int in_w);
        return (cfg_w + in_w - 1) / in_w;
    endfunction

    function automatic int lane_acc_lsb(input int k, input int conf_w, input int acc_w);
        return conf_w + k * acc_w;
    endfunction

    function automatic int lane_acc_msb(input int k, input int conf_w, input int acc_w);
        return conf_w + (k + 1) * acc_w - 1;
    endfunction

endpackage

// File: rtl/mac_cfg_loader.sv
// Byte-stream configuration loader for mac_cluster: assembles a shadow copy
// of the cfg word, commits it with a one-cycle cset strobe, then enables.
//
// state  | meaning
// -------+---------------------------------------------------------------
// EMPTY  | no valid configuration yet; en=0, accepting beats
// COMMIT | cfg just updated; cset=1, en=0, stream stalled for one cycle
// RUN    | cluster enabled on current cfg; next frame loads into shadow
module mac_cfg_loader
    import mac_pkg::*;
#(
    parameter int MAC_CONF_WIDTH = 4,
    parameter int MAC_MIN_WIDTH  = 8,
    parameter int MAC_ACC_WIDTH  = 32,
    parameter int IN_WIDTH       = 8
) (
    input  logic                                                clk,
    input  logic                                                rst,
    input  logic [IN_WIDTH-1:0]                                 in_data,
    input  logic                                                in_valid,
    input  logic                                                in_last,
    output logic                                                in_ready,
    output logic [cfg_width(MAC_CONF_WIDTH, MAC_ACC_WIDTH)-1:0] cfg,
    output logic                                                cset,
    output logic                                                en,
    output logic                                                frame_err
);

    localparam int CFG_W     = cfg_width(MAC_CONF_WIDTH, MAC_ACC_WIDTH);
    localparam int NUM_BEATS = num_beats(CFG_W, IN_WIDTH);
    localparam int CNT_W     = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;

    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NUM_BEATS - 1);

    localparam logic [1:0] ST_EMPTY  = EMPTY;
    localparam logic [1:0] ST_COMMIT = COMMIT;
    localparam logic [1:0] ST_RUN    = RUN;

    // Operand lanes must fit inside an accumulator lane
    if (MAC_MIN_WIDTH < 1 || MAC_MIN_WIDTH > MAC_ACC_WIDTH) begin : g_bad_lane_width
        $error("mac_cfg_loader: MAC_MIN_WIDTH must be in 1..MAC_ACC_WIDTH");
    end

    logic [1:0]       state;
    logic [CNT_W-1:0] beat_cnt;
    logic [CFG_W-1:0] shadow;
    logic [CFG_W-1:0] shadow_nxt;
    logic             beat_acc;
    logic             at_final;
    logic             good_last;
    logic             bad_frame;

    // Stall only for the commit bubble; reset holds the stream off
    assign in_ready  = !rst && (state != ST_COMMIT);
    assign beat_acc  = in_valid && in_ready;
    assign at_final  = (beat_cnt == LAST_BEAT);
    assign good_last = beat_acc && at_final && in_last;
    assign bad_frame = beat_acc && (in_last != at_final);

    assign cset = (state == ST_COMMIT);
    assign en   = (state == ST_RUN);

    // Merge the current beat into the shadow; bits of the final beat beyond
    // CFG_W have no destination and simply drop out
    always_comb begin
        shadow_nxt = shadow;
        for (int i = 0; i < CFG_W; i++) begin
            if (beat_acc && (beat_cnt == CNT_W'(i / IN_WIDTH))) begin
                shadow_nxt[i] = in_data[i % IN_WIDTH];
            end
        end
    end

    // Beat counter and shadow; any frame termination rewinds to beat 0
    always_ff @(posedge clk) begin
        if (rst) begin
            beat_cnt <= '0;
            shadow   <= '0;
        end else if (beat_acc) begin
            if (in_last || at_final) begin
                beat_cnt <= '0;
                shadow   <= '0;
            end else begin
                beat_cnt <= beat_cnt + 1'b1;
                shadow   <= shadow_nxt;
            end
        end
    end

    // cfg is written straight from the merged shadow on a good final beat
    always_ff @(posedge clk) begin
        if (rst) begin
            cfg       <= '0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= bad_frame;
            if (good_last) begin
                cfg <= shadow_nxt;
            end
        end
    end

    // Loader FSM
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_EMPTY;
        end else begin
            case (state)
                ST_EMPTY,
                ST_RUN:    if (good_last) state <= ST_COMMIT;
                ST_COMMIT: state <= ST_RUN;
                default:   state <= ST_EMPTY;
            endcase
        end
    end

endmodule

// File: tb/tb_mac_cfg_loader.sv
// Scoreboard bench for mac_cfg_loader: committed cfg words are compared
// against values queued when each good frame is streamed in.
module tb_mac_cfg_loader;
    import mac_pkg::*;

    localparam int CW = 132;
    localparam int NB = 17;
    localparam int FW = NB * 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [7:0]    in_data = '0;
    logic          in_valid = 1'b0;
    logic          in_last = 1'b0;
    logic          in_ready;
    logic [CW-1:0] cfg;
    logic          cset;
    logic          en;
    logic          frame_err;

    int            total = 0;
    int            bad = 0;
    int            err_seen = 0;
    int            cset_seen = 0;
    logic [CW-1:0] exp_q[$];
    logic          watch_run = 1'b0;
    logic [CW-1:0] held_cfg = '0;

    mac_cfg_loader dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .cfg       (cfg),
        .cset      (cset),
        .en        (en),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [CW-1:0] act, input logic [CW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, act, exp);
        end
    endtask

    // Output monitor: pops the scoreboard on every cset strobe
    always @(negedge clk) begin
        if (cset) begin
            cset_seen++;
            if (exp_q.size() == 0) chk("cset_unexpected", 1'b1, 1'b0);
            else                   chk("cfg_commit", cfg, exp_q.pop_front());
        end
        if (frame_err) err_seen++;
        if (watch_run && !cset) begin
            chk("run_en", en, 1'b1);
            chk("run_cfg_hold", cfg, held_cfg);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Called at a negedge; returns at the negedge after the beat is taken
    task automatic drive_beat(input logic [7:0] d, input logic l);
        int n = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("beat_ready", in_ready, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic send_frame(input logic [FW-1:0] fr, input int n, input int last_at, input int gap_max);
        for (int i = 0; i < n; i++) begin
            if (gap_max > 0) repeat ($urandom_range(gap_max, 0)) @(negedge clk);
            drive_beat(fr[i*8 +: 8], (i == last_at));
        end
    endtask

    function automatic logic [CW-1:0] rand_cfg();
        logic [159:0] r;
        r = {$urandom, $urandom, $urandom, $urandom, $urandom};
        return r[CW-1:0];
    endfunction

    initial begin
        logic [FW-1:0] fr;
        logic [CW-1:0] c2, c3, c4, c5, c6, c7;

        repeat (3) @(negedge clk);
        chk("rst_in_ready", in_ready, 1'b0);
        chk("rst_cfg", cfg, '0);
        chk("rst_cset", cset, 1'b0);
        chk("rst_en", en, 1'b0);
        chk("rst_frame_err", frame_err, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", in_ready, 1'b1);
        chk("post_rst_en", en, 1'b0);

        // Beats 0x01..0x11, LSB-first
        for (int i = 0; i < NB; i++) fr[i*8 +: 8] = 8'(i + 1);
        exp_q.push_back(fr[CW-1:0]);
        send_frame(fr, NB, NB - 1, 0);
        chk("t1_cset", cset, 1'b1);
        chk("t1_en_commit", en, 1'b0);
        chk("t1_ready_commit", in_ready, 1'b0);
        chk("t1_cfg_lo", cfg[7:0], fr[7:0]);
        chk("t1_cfg_top", cfg[131:128], 4'h1);
        @(negedge clk);
        chk("t1_cset_drop", cset, 1'b0);
        chk("t1_en", en, 1'b1);
        chk("t1_ready", in_ready, 1'b1);
        @(negedge clk);
        chk("t1_cset_once", cset_seen, 1);

        // QUAD + accumulate + signed, lanes preloaded 5..8
        c2 = {32'd8, 32'd7, 32'd6, 32'd5, 4'hE};
        fr = {4'h0, c2};
        exp_q.push_back(c2);
        send_frame(fr, NB, NB - 1, 0);
        @(negedge clk);
        chk("t2_mode", cfg[1:0], MAC_QUAD);
        chk("t2_acc", cfg[MODE_ACC_BIT], 1'b1);
        chk("t2_signed", cfg[MODE_SIGNED_BIT], 1'b1);
        for (int k = 0; k < 4; k++)
            chk("t2_lane", cfg[lane_acc_lsb(k, 4, 32) +: 32], 32'(5 + k));

        // in_last early on beat 9
        fr = {4'h0, rand_cfg()};
        send_frame(fr, 10, 9, 0);
        chk("t3_err", frame_err, 1'b1);
        chk("t3_cfg", cfg, c2);
        chk("t3_en", en, 1'b1);
        chk("t3_cset", cset, 1'b0);
        @(negedge clk);
        chk("t3_err_pulse", frame_err, 1'b0);
        c3 = rand_cfg();
        exp_q.push_back(c3);
        send_frame({4'h0, c3}, NB, NB - 1, 0);
        chk("t3_recover_cset", cset, 1'b1);
        @(negedge clk);

        // Missing in_last on beat 16
        fr = {4'h0, rand_cfg()};
        send_frame(fr, NB, -1, 0);
        chk("t4_err", frame_err, 1'b1);
        chk("t4_cset", cset, 1'b0);
        chk("t4_cfg", cfg, c3);
        chk("t4_en", en, 1'b1);
        @(negedge clk);
        chk("t4_cset_after", cset, 1'b0);
        chk("t4_err_pulse", frame_err, 1'b0);
        c4 = rand_cfg();
        exp_q.push_back(c4);
        send_frame({4'h0, c4}, NB, NB - 1, 0);
        chk("t4_recover_cset", cset, 1'b1);
        @(negedge clk);

        // Reload in RUN with random valid gaps
        held_cfg  = c4;
        watch_run = 1'b1;
        c5 = rand_cfg();
        exp_q.push_back(c5);
        send_frame({4'h0, c5}, NB, NB - 1, 3);
        watch_run = 1'b0;
        chk("t5_cset", cset, 1'b1);
        chk("t5_ready_commit", in_ready, 1'b0);
        @(negedge clk);
        chk("t5_ready", in_ready, 1'b1);
        chk("t5_en", en, 1'b1);

        // Reset after 8 beats of a frame
        fr = {4'h0, rand_cfg()};
        send_frame(fr, 8, -1, 0);
        rst = 1'b1;
        @(negedge clk);
        chk("t6_cfg", cfg, '0);
        chk("t6_en", en, 1'b0);
        chk("t6_ready", in_ready, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        c6 = rand_cfg();
        exp_q.push_back(c6);
        send_frame({4'h0, c6}, NB, NB - 1, 0);
        chk("t6_fresh_cset", cset, 1'b1);
        @(negedge clk);
        chk("t6_fresh_en", en, 1'b1);

        // Reset landing in the COMMIT cycle
        c7 = rand_cfg();
        exp_q.push_back(c7);
        send_frame({4'h0, c7}, NB, NB - 1, 0);
        rst = 1'b1;
        @(negedge clk);
        chk("t7_cset", cset, 1'b0);
        chk("t7_en", en, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        chk("t7_en_after", en, 1'b0);
        chk("t7_cfg", cfg, '0);

        repeat (2) @(negedge clk);
        chk("err_pulses", err_seen, 2);
        chk("commits", cset_seen, 7);
        chk("queue_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
